// File: rtl/dma_burst_seq.sv
// Splits a host DMA request into PCI bursts that respect a burst-length cap and 4 KB boundaries.
// Handles retry and disconnect re-issue, abort, and illegal-length flagging. All outputs are registered.
module dma_burst_seq #(
    parameter int MAX_BURST_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cnet_reprog,
    input  logic        go,
    input  logic        go_is_rd,
    input  logic [31:0] go_addr,
    input  logic [15:0] go_len,
    input  logic        done,
    input  logic        rd_undo,
    input  logic        abort_xfer,
    input  logic [8:0]  xfer_cnt,
    output logic        start,
    output logic        ld_xfer_cnt,
    output logic        reset_xfer_timer,
    output logic        xfer_is_rd,
    output logic [8:0]  xfer_cnt_start,
    output logic [3:0]  first_word_be,
    output logic [3:0]  last_word_be,
    output logic [29:0] dma_addr,
    output logic        dma_in_progress,
    output logic        enable_xfer_timer,
    output logic        seq_done,
    output logic        seq_error,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, NEXT} state_t;

    localparam logic [14:0] MAX_W = 15'(MAX_BURST_WORDS);

    state_t      state_q, state_d;
    logic        is_rd_q, is_rd_d;
    logic [14:0] remain_q, remain_d;
    logic        first_pend_q, first_pend_d;
    logic [3:0]  first_mask_q, first_mask_d;
    logic [3:0]  last_mask_q, last_mask_d;
    logic [8:0]  xfer_cnt_start_q, xfer_cnt_start_d;
    logic [3:0]  first_word_be_q, first_word_be_d;
    logic [3:0]  last_word_be_q, last_word_be_d;
    logic [29:0] dma_addr_q, dma_addr_d;
    logic        start_q, start_d;
    logic        ld_q, ld_d;
    logic        rxt_q, rxt_d;
    logic        in_prog_q, in_prog_d;
    logic        seq_done_q, seq_done_d;
    logic        seq_error_q, seq_error_d;

    logic [16:0] total_sum;
    logic [14:0] total_words;
    logic [1:0]  end_lane;
    logic [3:0]  go_first_mask, go_last_mask;
    logic [29:0] ld_addr;
    logic [14:0] ld_remain, to_bound, burst, acked;
    logic        ld_first, enter_load;
    logic [3:0]  ld_first_mask, ld_last_mask;

    always_comb begin
        total_sum   = {15'd0, go_addr[1:0]} + {1'b0, go_len} + 17'd3;
        total_words = total_sum[16:2];
        end_lane    = go_addr[1:0] + go_len[1:0] - 2'd1;
        case (go_addr[1:0])
            2'd0:    go_first_mask = 4'b0000;
            2'd1:    go_first_mask = 4'b0001;
            2'd2:    go_first_mask = 4'b0011;
            default: go_first_mask = 4'b0111;
        endcase
        case (end_lane)
            2'd3:    go_last_mask = 4'b0000;
            2'd2:    go_last_mask = 4'b1000;
            2'd1:    go_last_mask = 4'b1100;
            default: go_last_mask = 4'b1110;
        endcase

        // Burst sizing: from IDLE use the fresh request, otherwise the running position.
        ld_addr       = (state_q == IDLE) ? go_addr[31:2]  : dma_addr_q;
        ld_remain     = (state_q == IDLE) ? total_words    : remain_q;
        ld_first      = (state_q == IDLE) ? 1'b1           : first_pend_q;
        ld_first_mask = (state_q == IDLE) ? go_first_mask  : first_mask_q;
        ld_last_mask  = (state_q == IDLE) ? go_last_mask   : last_mask_q;
        to_bound      = 15'd1024 - {5'd0, ld_addr[9:0]};
        burst         = ld_remain;
        if (MAX_W < burst)    burst = MAX_W;
        if (to_bound < burst) burst = to_bound;

        acked = done ? {6'd0, xfer_cnt_start_q} : {6'd0, xfer_cnt_start_q - xfer_cnt};

        state_d          = state_q;
        is_rd_d          = is_rd_q;
        remain_d         = remain_q;
        first_pend_d     = first_pend_q;
        first_mask_d     = first_mask_q;
        last_mask_d      = last_mask_q;
        xfer_cnt_start_d = xfer_cnt_start_q;
        first_word_be_d  = first_word_be_q;
        last_word_be_d   = last_word_be_q;
        dma_addr_d       = dma_addr_q;
        start_d          = 1'b0;
        ld_d             = 1'b0;
        rxt_d            = 1'b0;
        seq_done_d       = 1'b0;
        seq_error_d      = 1'b0;
        enter_load       = 1'b0;

        case (state_q)
            IDLE: begin
                if (go) begin
                    if (go_len == 16'd0) begin
                        seq_error_d = 1'b1;
                    end else begin
                        enter_load   = 1'b1;
                        is_rd_d      = go_is_rd;
                        first_mask_d = go_first_mask;
                        last_mask_d  = go_last_mask;
                    end
                end
            end
            LOAD: begin
                state_d = START;
                start_d = 1'b1;
            end
            START: state_d = WAIT;
            WAIT: begin
                if (rd_undo) begin
                    state_d      = NEXT;
                    dma_addr_d   = dma_addr_q + {15'd0, acked};
                    remain_d     = remain_q - acked;
                    first_pend_d = first_pend_q && (acked == 15'd0);
                    seq_done_d   = (remain_q == acked);
                end
            end
            NEXT: begin
                if (remain_q != 15'd0) enter_load = 1'b1;
                else                   state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (enter_load) begin
            state_d          = LOAD;
            ld_d             = 1'b1;
            rxt_d            = (state_q == IDLE);
            xfer_cnt_start_d = burst[8:0];
            dma_addr_d       = ld_addr;
            remain_d         = ld_remain;
            first_pend_d     = ld_first;
            first_word_be_d  = ld_first ? ld_first_mask : 4'b0000;
            last_word_be_d   = (burst == ld_remain) ? ld_last_mask : 4'b0000;
        end

        // Abort wins over rd_undo and any pending load.
        if (abort_xfer && state_q != IDLE) begin
            state_d     = IDLE;
            seq_error_d = 1'b1;
            seq_done_d  = 1'b0;
            ld_d        = 1'b0;
            start_d     = 1'b0;
            rxt_d       = 1'b0;
        end

        in_prog_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset || cnet_reprog) begin
            state_q          <= IDLE;
            is_rd_q          <= 1'b0;
            remain_q         <= 15'd0;
            first_pend_q     <= 1'b0;
            first_mask_q     <= 4'b0000;
            last_mask_q      <= 4'b0000;
            xfer_cnt_start_q <= 9'd0;
            first_word_be_q  <= 4'b0000;
            last_word_be_q   <= 4'b0000;
            dma_addr_q       <= 30'd0;
            start_q          <= 1'b0;
            ld_q             <= 1'b0;
            rxt_q            <= 1'b0;
            in_prog_q        <= 1'b0;
            seq_done_q       <= 1'b0;
            seq_error_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            is_rd_q          <= is_rd_d;
            remain_q         <= remain_d;
            first_pend_q     <= first_pend_d;
            first_mask_q     <= first_mask_d;
            last_mask_q      <= last_mask_d;
            xfer_cnt_start_q <= xfer_cnt_start_d;
            first_word_be_q  <= first_word_be_d;
            last_word_be_q   <= last_word_be_d;
            dma_addr_q       <= dma_addr_d;
            start_q          <= start_d;
            ld_q             <= ld_d;
            rxt_q            <= rxt_d;
            in_prog_q        <= in_prog_d;
            seq_done_q       <= seq_done_d;
            seq_error_q      <= seq_error_d;
        end
    end

    assign start             = start_q;
    assign ld_xfer_cnt       = ld_q;
    assign reset_xfer_timer  = rxt_q;
    assign xfer_is_rd        = is_rd_q;
    assign xfer_cnt_start    = xfer_cnt_start_q;
    assign first_word_be     = first_word_be_q;
    assign last_word_be      = last_word_be_q;
    assign dma_addr          = dma_addr_q;
    assign dma_in_progress   = in_prog_q;
    assign enable_xfer_timer = in_prog_q;
    assign seq_done          = seq_done_q;
    assign seq_error         = seq_error_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_dma_burst_seq.sv
// Self-checking bench for dma_burst_seq: expected bursts are queued when a DMA is requested
// and compared against each ld_xfer_cnt pulse.
module tb_dma_burst_seq;

    localparam int MAX = 16;

    logic        clk = 1'b0;
    logic        reset, cnet_reprog, go, go_is_rd, done, rd_undo, abort_xfer;
    logic [31:0] go_addr;
    logic [15:0] go_len;
    logic [8:0]  xfer_cnt;
    logic        start, ld_xfer_cnt, reset_xfer_timer, xfer_is_rd;
    logic [8:0]  xfer_cnt_start;
    logic [3:0]  first_word_be, last_word_be;
    logic [29:0] dma_addr;
    logic        dma_in_progress, enable_xfer_timer, seq_done, seq_error;
    logic [2:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    logic [46:0] exp_q[$];

    always #5 clk = ~clk;

    dma_burst_seq #(.MAX_BURST_WORDS(MAX)) dut (
        .clk(clk), .reset(reset), .cnet_reprog(cnet_reprog), .go(go), .go_is_rd(go_is_rd),
        .go_addr(go_addr), .go_len(go_len), .done(done), .rd_undo(rd_undo),
        .abort_xfer(abort_xfer), .xfer_cnt(xfer_cnt), .start(start), .ld_xfer_cnt(ld_xfer_cnt),
        .reset_xfer_timer(reset_xfer_timer), .xfer_is_rd(xfer_is_rd),
        .xfer_cnt_start(xfer_cnt_start), .first_word_be(first_word_be),
        .last_word_be(last_word_be), .dma_addr(dma_addr), .dma_in_progress(dma_in_progress),
        .enable_xfer_timer(enable_xfer_timer), .seq_done(seq_done), .seq_error(seq_error),
        .dbg_state(dbg_state)
    );

    function automatic logic [46:0] pack_exp(input int n, input int a, input logic [3:0] f,
                                             input logic [3:0] l);
        return {9'(n), 30'(a), f, l};
    endfunction

    // Reference burst split straight from the request fields.
    task automatic model_push(input logic [31:0] a, input logic [15:0] len);
        int total, wa, rem, b, bnd, ei;
        logic [3:0] fm, lm;
        logic first;
        total = (int'(a[1:0]) + int'(len) + 3) / 4;
        wa = int'(a[31:2]);
        ei = (int'(a[1:0]) + int'(len) - 1) % 4;
        case (a[1:0])
            2'd0: fm = 4'b0000;
            2'd1: fm = 4'b0001;
            2'd2: fm = 4'b0011;
            default: fm = 4'b0111;
        endcase
        case (ei)
            3: lm = 4'b0000;
            2: lm = 4'b1000;
            1: lm = 4'b1100;
            default: lm = 4'b1110;
        endcase
        rem = total;
        first = 1'b1;
        while (rem > 0) begin
            b = rem;
            if (MAX < b) b = MAX;
            bnd = 1024 - (wa % 1024);
            if (bnd < b) b = bnd;
            exp_q.push_back(pack_exp(b, wa, first ? fm : 4'b0000, (b == rem) ? lm : 4'b0000));
            wa = wa + b;
            rem = rem - b;
            first = 1'b0;
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_go(input logic [31:0] a, input logic [15:0] len, input logic rd);
        @(negedge clk);
        go = 1'b1; go_addr = a; go_len = len; go_is_rd = rd;
        @(negedge clk);
        go = 1'b0;
    endtask

    // One burst: wait for load, compare against the queue, then end it with rd_undo.
    task automatic run_burst(input logic first_load, input logic rd_exp, input logic done_v,
                             input logic [8:0] cnt_v, input logic exp_done);
        logic [46:0] exp_v, got_v;
        int n;
        n = 0;
        while (ld_xfer_cnt !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ld_xfer_cnt !== 1'b1) begin
            failures++;
            $display("FAIL load_timeout ld_xfer_cnt=%b expected 1", ld_xfer_cnt);
            exp_q.delete();
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_empty unexpected burst len=%0d addr=%h", xfer_cnt_start, dma_addr);
            return;
        end
        exp_v = exp_q.pop_front();
        got_v = {xfer_cnt_start, dma_addr, first_word_be, last_word_be};
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL burst got len=%0d addr=%h fbe=%b lbe=%b expected len=%0d addr=%h fbe=%b lbe=%b",
                     got_v[46:38], got_v[37:8], got_v[7:4], got_v[3:0],
                     exp_v[46:38], exp_v[37:8], exp_v[7:4], exp_v[3:0]);
        end
        checks++;
        if (reset_xfer_timer !== first_load) begin
            failures++;
            $display("FAIL reset_xfer_timer got %b expected %b", reset_xfer_timer, first_load);
        end
        checks++;
        if ({xfer_is_rd, dma_in_progress, enable_xfer_timer} !== {rd_exp, 2'b11}) begin
            failures++;
            $display("FAIL status got rd/inprog/tmr=%b%b%b expected %b11",
                     xfer_is_rd, dma_in_progress, enable_xfer_timer, rd_exp);
        end
        @(negedge clk);
        checks++;
        if ({start, ld_xfer_cnt, reset_xfer_timer} !== 3'b100) begin
            failures++;
            $display("FAIL start_pulse got start/ld/rxt=%b%b%b expected 100",
                     start, ld_xfer_cnt, reset_xfer_timer);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({start, xfer_cnt_start, dma_addr} !== {1'b0, exp_v[46:8]}) begin
            failures++;
            $display("FAIL wait_stable got start=%b len=%0d addr=%h expected 0 %0d %h",
                     start, xfer_cnt_start, dma_addr, exp_v[46:38], exp_v[37:8]);
        end
        rd_undo = 1'b1; done = done_v; xfer_cnt = cnt_v;
        @(negedge clk);
        rd_undo = 1'b0;
        checks++;
        if ({seq_done, seq_error} !== {exp_done, 1'b0}) begin
            failures++;
            $display("FAIL seq_done got done/err=%b%b expected %b0", seq_done, seq_error, exp_done);
        end
        @(negedge clk);
        done = 1'b0; xfer_cnt = 9'd0;
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if ({dma_in_progress, enable_xfer_timer, ld_xfer_cnt, dbg_state} !== 6'd0) begin
            failures++;
            $display("FAIL %s_idle got inprog/tmr/ld=%b%b%b state=%0d expected 000 0",
                     tag, dma_in_progress, enable_xfer_timer, ld_xfer_cnt, dbg_state);
        end
    endtask

    task automatic run_dma(input logic [31:0] a, input logic [15:0] len, input logic rd);
        logic first;
        int iter;
        model_push(a, len);
        start_go(a, len, rd);
        first = 1'b1;
        iter = 0;
        while (exp_q.size() > 0 && iter < 64) begin
            run_burst(first, rd, 1'b1, 9'd0, exp_q.size() == 1);
            first = 1'b0;
            iter++;
        end
        check_idle("dma_end");
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if ({start, ld_xfer_cnt, reset_xfer_timer, xfer_is_rd, xfer_cnt_start, first_word_be,
             last_word_be, dma_addr, dma_in_progress, enable_xfer_timer, seq_done, seq_error} !== 55'd0) begin
            failures++;
            $display("FAIL reset_outputs got len=%0d addr=%h inprog=%b expected all zero",
                     xfer_cnt_start, dma_addr, dma_in_progress);
        end
        check_idle("reset");
    endtask

    task automatic test_fixed_cases();
        run_dma(32'h0000_1000, 16'd64, 1'b1);
        run_dma(32'h0000_1002, 16'd100, 1'b0);
        run_dma(32'h0000_0FF8, 16'd32, 1'b1);
        run_dma(32'h0000_1001, 16'd2, 1'b0);
        run_dma(32'h0000_2FC0, 16'd256, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [15:0] len;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) a = 32'h0000_3000 - 32'($urandom_range(1, 80));
            else            a = 32'($urandom_range(0, 32'h0FFF_FFFF));
            len = 16'($urandom_range(1, 300));
            run_dma(a, len, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_retry();
        exp_q.push_back(pack_exp(16, 32'h800, 4'b0001, 4'b1000));
        exp_q.push_back(pack_exp(16, 32'h800, 4'b0001, 4'b1000));
        exp_q.push_back(pack_exp(5, 32'h80B, 4'b0000, 4'b1000));
        start_go(32'h0000_2001, 16'd62, 1'b1);
        run_burst(1'b1, 1'b1, 1'b0, 9'd16, 1'b0);
        run_burst(1'b0, 1'b1, 1'b0, 9'd5, 1'b0);
        run_burst(1'b0, 1'b1, 1'b1, 9'd0, 1'b1);
        check_idle("retry");
    endtask

    task automatic test_abort();
        start_go(32'h0000_4000, 16'd64, 1'b0);
        repeat (2) @(negedge clk);
        abort_xfer = 1'b1; rd_undo = 1'b1; done = 1'b1;
        @(negedge clk);
        abort_xfer = 1'b0; rd_undo = 1'b0; done = 1'b0;
        checks++;
        if ({seq_error, seq_done, dma_in_progress, enable_xfer_timer} !== 4'b1000) begin
            failures++;
            $display("FAIL abort_wait got err/done/inprog/tmr=%b%b%b%b expected 1000",
                     seq_error, seq_done, dma_in_progress, enable_xfer_timer);
        end
        start_go(32'h0000_4000, 16'd64, 1'b0);
        abort_xfer = 1'b1;
        @(negedge clk);
        abort_xfer = 1'b0;
        checks++;
        if ({seq_error, start, dma_in_progress} !== 3'b100) begin
            failures++;
            $display("FAIL abort_load got err/start/inprog=%b%b%b expected 100",
                     seq_error, start, dma_in_progress);
        end
        @(negedge clk);
        checks++;
        if (seq_error !== 1'b0) begin
            failures++;
            $display("FAIL abort_pulse_width seq_error=%b expected 0", seq_error);
        end
        check_idle("abort");
    endtask

    task automatic test_zero_len();
        start_go(32'h0000_0100, 16'd0, 1'b0);
        checks++;
        if ({seq_error, ld_xfer_cnt, dma_in_progress} !== 3'b100) begin
            failures++;
            $display("FAIL zero_len got err/ld/inprog=%b%b%b expected 100",
                     seq_error, ld_xfer_cnt, dma_in_progress);
        end
        @(negedge clk);
        checks++;
        if ({seq_error, ld_xfer_cnt} !== 2'b00) begin
            failures++;
            $display("FAIL zero_len_after got err/ld=%b%b expected 00", seq_error, ld_xfer_cnt);
        end
    endtask

    task automatic test_go_ignored();
        start_go(32'h0000_5000, 16'd32, 1'b0);
        go = 1'b1; go_addr = 32'h0000_9000; go_len = 16'd8; go_is_rd = 1'b1;
        repeat (2) @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        checks++;
        if ({ld_xfer_cnt, xfer_is_rd, xfer_cnt_start, dma_addr} !== {2'b00, 9'd8, 30'h1400}) begin
            failures++;
            $display("FAIL go_ignored got ld=%b rd=%b len=%0d addr=%h expected 0 0 8 1400",
                     ld_xfer_cnt, xfer_is_rd, xfer_cnt_start, dma_addr);
        end
        rd_undo = 1'b1; done = 1'b1;
        @(negedge clk);
        rd_undo = 1'b0; done = 1'b0;
        checks++;
        if (seq_done !== 1'b1) begin
            failures++;
            $display("FAIL go_ignored_done seq_done=%b expected 1", seq_done);
        end
        @(negedge clk);
        check_idle("go_ignored");
    endtask

    task automatic test_reset_mid(input logic use_reprog);
        start_go(32'h0000_6003, 16'd64, 1'b1);
        repeat (2) @(negedge clk);
        if (use_reprog) cnet_reprog = 1'b1;
        else            reset = 1'b1;
        @(negedge clk);
        cnet_reprog = 1'b0; reset = 1'b0;
        checks++;
        if ({start, ld_xfer_cnt, reset_xfer_timer, xfer_is_rd, xfer_cnt_start, first_word_be,
             last_word_be, dma_addr, dma_in_progress, enable_xfer_timer, seq_done, seq_error} !== 55'd0) begin
            failures++;
            $display("FAIL mid_reset reprog=%b got rd=%b len=%0d fbe=%b addr=%h inprog=%b expected all zero",
                     use_reprog, xfer_is_rd, xfer_cnt_start, first_word_be, dma_addr, dma_in_progress);
        end
        @(negedge clk);
        checks++;
        if ({seq_done, seq_error} !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset_pulses got done/err=%b%b expected 00", seq_done, seq_error);
        end
        check_idle("mid_reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; cnet_reprog = 1'b0; go = 1'b0; go_is_rd = 1'b0; go_addr = 32'd0;
        go_len = 16'd0; done = 1'b0; rd_undo = 1'b0; abort_xfer = 1'b0; xfer_cnt = 9'd0;
        test_reset();
        test_fixed_cases();
        test_retry();
        test_abort();
        test_zero_len();
        test_go_ignored();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
